gate_sweep_ctrl: RTL and testbench
==================================

Name: gate_sweep_ctrl

Overview:
Self-checking sequencer for a 2-input combinational gate under test, such as the De Morgan NOR-equivalent cells. On a start pulse it drives all four {a,b} input vectors in order, holding each for a programmable settle time. At the end of each hold it samples the gate output and compares it with an expected truth table. It reports the observed table, the mismatch count and a pass flag. It replaces free-running delay-toggle stimulus with a clocked, repeatable sweep usable on the board and in simulation.

Parameters:
SETTLE, 4, hold cycles per vector (>=1); the sample is taken on the last hold cycle.
EXP_TABLE, 4'b0001, expected gate output; bit i is the expected value for vector i = {a,b}. The default is ~(a|b) = ~a & ~b.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a sweep; ignored while busy
abort  in  1  cancels the sweep in progress
gate_a  out  1  drive to gate input a (registered)
gate_b  out  1  drive to gate input b (registered)
gate_c  in  1  gate output under test
busy  out  1  high from the first drive cycle through the last sample cycle
done  out  1  one-cycle pulse when the sweep completes
pass  out  1  high when err_cnt==0 after done; held until the next start
obs_table  out  4  sampled gate_c; bit i is the result for vector i
err_cnt  out  3  mismatches in the current or last sweep (0..4)
vec_idx  out  2  index of the vector currently driven

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous active-low. While rst_n=0, all outputs are 0 (gate_a, gate_b, busy, done, pass, obs_table, err_cnt, vec_idx) and the FSM is in IDLE.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 and abort=0 → DRIVE.
  - On that edge: clear obs_table, err_cnt and pass; set vec_idx=0 and gate_a/gate_b=0/0; load the settle counter with 0.
- DRIVE:
  - busy=1 and {gate_a,gate_b}=vec_idx.
  - The counter increments each cycle.
  - When counter==SETTLE-1: latch gate_c into obs_table[vec_idx]; if it differs from EXP_TABLE[vec_idx], increment err_cnt; reset the counter.
  - If vec_idx<3, increment vec_idx and update gate_a/gate_b on the same edge.
  - If vec_idx==3 → DONE.
- DONE:
  - One cycle only: done=1, busy=0, pass=(err_cnt==0), gate_a/gate_b return to 0 → IDLE.
- Latency: start sampled at cycle T → done high in cycle T+1+4*SETTLE. With SETTLE=4, start at cycle 0 gives done at cycle 17.
- start while busy or in DONE: ignored, with no restart and no queueing.
- abort in DRIVE:
  - Next edge → IDLE; busy=0, gate_a/gate_b=0, no done pulse, pass=0.
  - Partial obs_table and err_cnt are held.
- abort in IDLE: no effect. When start and abort are both high in IDLE, abort wins and the start is dropped.
- Reset mid-sweep: immediate return to reset values with no done pulse.
- Widths:
  - Settle counter is $clog2(SETTLE+1) bits.
  - err_cnt saturates at 4 by construction; no wrap is possible.
  - vec_idx never wraps within a sweep.

Optional Feature:
GATE_SWEEP_FIRST_FAIL_EN.
- Defined: adds output first_fail_idx[1:0] and first_fail_vld.
  - On the first mismatch of a sweep, capture vec_idx and set first_fail_vld=1.
  - Later mismatches do not overwrite the capture.
  - Both are cleared on start and on reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package gate_sweep_pkg:
  - state enum (IDLE, DRIVE, DONE)
  - NUM_VEC=4
  - VEC_W=2
  - ERR_W=3
- Sub-module settle_timer: parameter SETTLE; inputs clk, rst_n, clr; output tick, high on the cycle the count equals SETTLE-1, with auto-reload.
- The FSM, compare and table logic stay in gate_sweep_ctrl.

Test Plan:
- Correct NOR model on gate_c, SETTLE=4, start at cycle 0 → vectors 00,01,10,11 each held 4 cycles; done at cycle 17; obs_table=4'b0001, err_cnt=0, pass=1.
- gate_c stuck at 1 → obs_table=4'b1111, err_cnt=3, pass=0; with GATE_SWEEP_FIRST_FAIL_EN, first_fail_idx=1 and first_fail_vld=1.
- start pulsed again at cycle 8 during a sweep → ignored; done still at cycle 17 and exactly one done pulse.
- abort at cycle 7 (vector 1 in progress) → busy=0 at cycle 8, gate_a/gate_b=0, no done, obs_table bit0 valid, pass=0.
- start and abort high together in IDLE → stays IDLE, busy stays 0.
- rst_n low for 1 cycle at cycle 10 (asynchronous, mid-cycle) → all outputs 0 immediately; a fresh start then completes normally with pass=1.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared types and sizes for the 2-input gate sweep sequencer.
package gate_sweep_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;
  localparam int ERR_W   = 3;
endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Control/status bundle of gate_sweep_ctrl; master is the host, slave is the sequencer.
// GATE_SWEEP_FIRST_FAIL_EN adds the first-mismatch capture signals.
interface gate_sweep_ctrl_if;
  import gate_sweep_pkg::*;

  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_VEC-1:0] obs_table;
  logic [ERR_W-1:0]   err_cnt;
  logic [VEC_W-1:0]   vec_idx;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic [VEC_W-1:0]   first_fail_idx;
  logic               first_fail_vld;
`endif

  modport master (
    output start, abort,
    input  busy, done, pass, obs_table, err_cnt, vec_idx
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    , input first_fail_idx, first_fail_vld
`endif
  );

  modport slave (
    input  start, abort,
    output busy, done, pass, obs_table, err_cnt, vec_idx
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    , output first_fail_idx, first_fail_vld
`endif
  );
endinterface

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Hold-time counter: tick on the cycle the count reaches SETTLE-1, then reloads to 0.
// clr forces the count to 0 and suppresses tick.
module settle_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all four {a,b} vectors into a gate, samples its output after SETTLE cycles each
// and scores it against EXP_TABLE. Optional GATE_SWEEP_FIRST_FAIL_EN captures the first bad vector.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int                 SETTLE    = 4,
  parameter logic [NUM_VEC-1:0] EXP_TABLE = 4'b0001
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              gate_a,
  output logic              gate_b,
  input  logic              gate_c,
  gate_sweep_ctrl_if.slave  ctl
);
  state_t             state;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [NUM_VEC-1:0] obs_q;
  logic [ERR_W-1:0]   err_q;
  logic [VEC_W-1:0]   vec_q;
  logic               tick;
  logic               mismatch;
  logic [ERR_W-1:0]   err_nxt;
  logic [VEC_W-1:0]   vec_nxt;

`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic [VEC_W-1:0]   ff_idx_q;
  logic               ff_vld_q;
  assign ctl.first_fail_idx = ff_idx_q;
  assign ctl.first_fail_vld = ff_vld_q;
`endif

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != DRIVE),
    .tick  (tick)
  );

  assign mismatch = (gate_c != EXP_TABLE[vec_q]);
  assign err_nxt  = err_q + ERR_W'(mismatch);
  assign vec_nxt  = vec_q + 1'b1;

  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.pass      = pass_q;
  assign ctl.obs_table = obs_q;
  assign ctl.err_cnt   = err_q;
  assign ctl.vec_idx   = vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      obs_q  <= '0;
      err_q  <= '0;
      vec_q  <= '0;
      gate_a <= 1'b0;
      gate_b <= 1'b0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      ff_idx_q <= '0;
      ff_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // abort beats a simultaneous start
          if (ctl.start && !ctl.abort) begin
            state  <= DRIVE;
            busy_q <= 1'b1;
            pass_q <= 1'b0;
            obs_q  <= '0;
            err_q  <= '0;
            vec_q  <= '0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            ff_idx_q <= '0;
            ff_vld_q <= 1'b0;
`endif
          end
        end

        DRIVE: begin
          if (ctl.abort) begin
            // partial table and error count stay visible for debug
            state  <= IDLE;
            busy_q <= 1'b0;
            pass_q <= 1'b0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
          end else if (tick) begin
            obs_q[vec_q] <= gate_c;
            err_q        <= err_nxt;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            if (mismatch && !ff_vld_q) begin
              ff_idx_q <= vec_q;
              ff_vld_q <= 1'b1;
            end
`endif
            if (vec_q == VEC_W'(NUM_VEC - 1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_nxt == '0);
              gate_a <= 1'b0;
              gate_b <= 1'b0;
            end else begin
              vec_q  <= vec_nxt;
              gate_a <= vec_nxt[1];
              gate_b <= vec_nxt[0];
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl with SETTLE=4 and a NOR (or stuck-at-1) gate model.
// Cycle 0 is the cycle in which start is held high; samples are taken 1ns after each rising edge.
module tb_gate_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gate_a, gate_b, gate_c;
  logic stuck = 1'b0;

  int cyc = 0;
  int done_cnt = 0;
  int n_total = 0;
  int n_pass = 0;

  gate_sweep_ctrl_if sif();

  gate_sweep_ctrl #(.SETTLE(4), .EXP_TABLE(4'b0001)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .gate_a (gate_a),
    .gate_b (gate_b),
    .gate_c (gate_c),
    .ctl    (sif.slave)
  );

  assign gate_c = stuck ? 1'b1 : ~(gate_a | gate_b);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sif.done === 1'b1) done_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic begin_sweep();
    cyc = 0;
    done_cnt = 0;
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
  endtask

  initial begin
    sif.start = 1'b0;
    sif.abort = 1'b0;
    #12;
    chk("rst_busy", 32'(sif.busy), 0);
    chk("rst_done", 32'(sif.done), 0);
    chk("rst_pass", 32'(sif.pass), 0);
    chk("rst_obs", 32'(sif.obs_table), 0);
    chk("rst_err", 32'(sif.err_cnt), 0);
    chk("rst_vec", 32'(sif.vec_idx), 0);
    chk("rst_gate", 32'({gate_a, gate_b}), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // NOR sweep with a stray start at cycle 8
    begin_sweep();
    chk("nor_c1_busy", 32'(sif.busy), 1);
    chk("nor_c1_gate", 32'({gate_a, gate_b}), 0);
    chk("nor_c1_vec", 32'(sif.vec_idx), 0);
    run_to(4);
    chk("nor_c4_vec", 32'(sif.vec_idx), 0);
    run_to(5);
    chk("nor_c5_vec", 32'(sif.vec_idx), 1);
    chk("nor_c5_gate", 32'({gate_a, gate_b}), 32'b01);
    chk("nor_c5_obs", 32'(sif.obs_table), 32'b0001);
    run_to(8);
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
    chk("nor_c9_gate", 32'({gate_a, gate_b}), 32'b10);
    run_to(13);
    chk("nor_c13_gate", 32'({gate_a, gate_b}), 32'b11);
    run_to(16);
    chk("nor_c16_busy", 32'(sif.busy), 1);
    chk("nor_c16_done", 32'(sif.done), 0);
    run_to(17);
    chk("nor_c17_done", 32'(sif.done), 1);
    chk("nor_c17_busy", 32'(sif.busy), 0);
    chk("nor_c17_pass", 32'(sif.pass), 1);
    chk("nor_c17_obs", 32'(sif.obs_table), 32'b0001);
    chk("nor_c17_err", 32'(sif.err_cnt), 0);
    chk("nor_c17_gate", 32'({gate_a, gate_b}), 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    chk("nor_ff_vld", 32'(sif.first_fail_vld), 0);
`endif
    run_to(30);
    chk("nor_done_cnt", 32'(done_cnt), 1);
    chk("nor_pass_hold", 32'(sif.pass), 1);
    chk("nor_idle_busy", 32'(sif.busy), 0);

    // stuck-at-1 gate
    stuck = 1'b1;
    begin_sweep();
    chk("stk_c1_pass", 32'(sif.pass), 0);
    run_to(17);
    chk("stk_done", 32'(sif.done), 1);
    chk("stk_obs", 32'(sif.obs_table), 32'b1111);
    chk("stk_err", 32'(sif.err_cnt), 3);
    chk("stk_pass", 32'(sif.pass), 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    chk("stk_ff_idx", 32'(sif.first_fail_idx), 1);
    chk("stk_ff_vld", 32'(sif.first_fail_vld), 1);
`endif
    run_to(20);
    stuck = 1'b0;

    // abort during vector 1
    begin_sweep();
    run_to(7);
    sif.abort = 1'b1;
    step();
    sif.abort = 1'b0;
    chk("abt_c8_busy", 32'(sif.busy), 0);
    chk("abt_c8_gate", 32'({gate_a, gate_b}), 0);
    chk("abt_c8_obs", 32'(sif.obs_table), 32'b0001);
    chk("abt_c8_err", 32'(sif.err_cnt), 0);
    chk("abt_c8_pass", 32'(sif.pass), 0);
    run_to(25);
    chk("abt_done_cnt", 32'(done_cnt), 0);
    chk("abt_busy", 32'(sif.busy), 0);

    // start and abort together in IDLE
    cyc = 0;
    done_cnt = 0;
    sif.start = 1'b1;
    sif.abort = 1'b1;
    step();
    sif.start = 1'b0;
    sif.abort = 1'b0;
    chk("sa_busy", 32'(sif.busy), 0);
    run_to(20);
    chk("sa_busy_late", 32'(sif.busy), 0);
    chk("sa_done_cnt", 32'(done_cnt), 0);

    // asynchronous reset mid-sweep, then a clean sweep
    begin_sweep();
    run_to(10);
    chk("rs_c10_busy", 32'(sif.busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rs_busy", 32'(sif.busy), 0);
    chk("rs_gate", 32'({gate_a, gate_b}), 0);
    chk("rs_obs", 32'(sif.obs_table), 0);
    chk("rs_vec", 32'(sif.vec_idx), 0);
    chk("rs_err", 32'(sif.err_cnt), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("rs_after_busy", 32'(sif.busy), 0);
    begin_sweep();
    run_to(17);
    chk("rs2_done", 32'(sif.done), 1);
    chk("rs2_pass", 32'(sif.pass), 1);
    chk("rs2_obs", 32'(sif.obs_table), 32'b0001);
    chk("rs2_err", 32'(sif.err_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
